// File: rtl/alu_legv8_pkg.sv
// alu_legv8_pkg: shared FS op codes and FSM state encodings for alu_seq_legv8
package alu_legv8_pkg;
  typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SHL, OP_SHR, OP_MUL, OP_NOP} op_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: bit-serial shift and shift-add multiply datapath (multiply only when ALU_MUL_EN is defined)
module alu_seq_iter #(
  parameter int WIDTH = 64,
  parameter int CW = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             left,
`ifdef ALU_MUL_EN
  input  logic             mul,
  input  logic [WIDTH-1:0] b,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [CW-1:0]    cnt_init,
  output logic             last,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] acc, acc_init;
  logic [CW-1:0] cnt;
  logic left_q;
`ifdef ALU_MUL_EN
  logic mul_q;
  logic [WIDTH-1:0] mcd, mpl;
  assign acc_init = mul ? '0 : a;
  assign nxt = mul_q ? acc + (mpl[0] ? mcd : '0) : left_q ? acc << 1 : acc >> 1;
  // multiplicand walks left and multiplier walks right one bit per step
  always_ff @(posedge clk)
    if (rst) begin
      mul_q <= 1'b0;
      mcd <= '0;
      mpl <= '0;
    end else if (load) begin
      mul_q <= mul;
      mcd <= a;
      mpl <= b;
    end else if (step) begin
      mcd <= mcd << 1;
      mpl <= mpl >> 1;
    end
`else
  assign acc_init = a;
  assign nxt = left_q ? acc << 1 : acc >> 1;
`endif
  assign last = cnt == CW'(1);
  // accumulator and remaining-iteration counter; last marks the final step
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      left_q <= 1'b0;
    end else if (load) begin
      acc <= acc_init;
      cnt <= cnt_init;
      left_q <= left;
    end else if (step) begin
      acc <= nxt;
      cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/alu_seq_legv8.sv
// alu_seq_legv8: LEGv8-style ALU with valid/ready handshake; iterative shifts, optional multiply via ALU_MUL_EN
module alu_seq_legv8
  import alu_legv8_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);
  op_t op;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_in, b_in, res, it_nxt;
  logic [WIDTH:0] sum;
  logic [SHW-1:0] amt;
  logic [SHW:0] cnt_init;
  logic [1:0] cv;
  logic is_shift, is_mul, iter, accept, last, ovf;
  assign op = op_t'(FS[4:2]);
  assign a_in = FS[0] ? ~A : A;
  assign b_in = FS[1] ? ~B : B;
  assign sum = {1'b0, a_in} + {1'b0, b_in} + (WIDTH+1)'(C0);
  assign ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
  assign amt = B[SHW-1:0];
  assign is_shift = op == OP_SHL || op == OP_SHR;
`ifdef ALU_MUL_EN
  assign is_mul = op == OP_MUL;
`else
  assign is_mul = 1'b0;
`endif
  assign iter = (is_shift && amt != '0) || is_mul;
  assign accept = state == IDLE && in_valid;
  assign cnt_init = is_mul ? (SHW+1)'(WIDTH) : {1'b0, amt};
  // zero-amount shifts pass A through; undefined ops resolve to zero
  assign res = op == OP_AND ? a_in & b_in :
               op == OP_OR  ? a_in | b_in :
               op == OP_ADD ? sum[WIDTH-1:0] :
               op == OP_XOR ? a_in ^ b_in :
               is_shift     ? A : '0;
  assign cv = op == OP_ADD ? {ovf, sum[WIDTH]} : 2'b00;
  alu_seq_iter #(.WIDTH(WIDTH), .CW(SHW+1)) u_iter (
    .clk      (clock),
    .rst      (reset),
    .load     (accept && iter),
    .step     (state == BUSY),
    .left     (op == OP_SHL),
`ifdef ALU_MUL_EN
    .mul      (is_mul),
    .b        (B),
`endif
    .a        (A),
    .cnt_init (cnt_init),
    .last     (last),
    .nxt      (it_nxt)
  );
  // state register
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_nxt;
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = in_valid ? (iter ? BUSY : DONE) : IDLE;
      BUSY: state_nxt = last ? DONE : BUSY;
      DONE: state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // handshake outputs
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  // result and flags, written only when entering DONE so they hold while stalled
  always_ff @(posedge clock)
    if (reset) begin
      F <= '0;
      status <= '0;
    end else if (accept && !iter) begin
      F <= res;
      status <= {cv, res[WIDTH-1], res == '0};
    end else if (state == BUSY && last) begin
      F <= it_nxt;
      status <= {2'b00, it_nxt[WIDTH-1], it_nxt == '0};
    end
endmodule

// File: tb/tb_alu_seq_legv8.sv
// tb_alu_seq_legv8: table-driven scoreboard bench for alu_seq_legv8 (WIDTH=64)
module tb_alu_seq_legv8;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] f;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0, C0 = 1'b0;
  logic in_ready, out_valid;
  logic [63:0] A = '0, B = '0, F;
  logic [4:0] FS = '0;
  logic [3:0] status;
  int checks = 0, failures = 0;
  vec_t vt[16];
  vec_t sb[$];

  alu_seq_legv8 #(.WIDTH(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .FS(FS), .C0(C0), .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .status(status)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic do_op(input string nm, input vec_t v, input int hold);
    int n;
    vec_t e;
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    A = v.a; B = v.b; FS = v.fs; C0 = v.c0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    sb.push_back(v);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(v.lat));
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, " F"}, F, e.f);
      chk({nm, " status"}, 64'(status), 64'(e.st));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk({nm, " hold F"}, F, e.f);
      chk({nm, " hold status"}, 64'(status), 64'(e.st));
      chk({nm, " hold out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    vt[0]  = '{64'd6, 64'd3, 5'b00000, 1'b0, 64'd2, 4'b0000, 1};
    vt[1]  = '{64'd6, 64'd3, 5'b01000, 1'b0, 64'd9, 4'b0000, 1};
    vt[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, 1};
    vt[3]  = '{64'd6, 64'd3, 5'b00011, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0010, 1};
    vt[4]  = '{64'd6, 64'd3, 5'b00111, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0010, 1};
    vt[5]  = '{64'h8000_0000_0000_0000, 64'd63, 5'b10100, 1'b0, 64'd1, 4'b0000, 64};
    vt[6]  = '{64'h1234, 64'd0, 5'b10000, 1'b0, 64'h1234, 4'b0000, 1};
    vt[7]  = '{64'd1, 64'd4, 5'b10000, 1'b0, 64'd16, 4'b0000, 5};
    vt[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'b01000, 1'b1, 64'd0, 4'b0101, 1};
    vt[9]  = '{64'd5, 64'd5, 5'b01100, 1'b0, 64'd0, 4'b0001, 1};
    vt[10] = '{64'd7, 64'd9, 5'b11100, 1'b0, 64'd0, 4'b0001, 1};
`ifdef ALU_MUL_EN
    vt[11] = '{64'd7, 64'd9, 5'b11000, 1'b0, 64'd63, 4'b0000, 65};
`else
    vt[11] = '{64'd7, 64'd9, 5'b11000, 1'b0, 64'd0, 4'b0001, 1};
`endif
    vt[12] = '{64'd5, 64'd3, 5'b01010, 1'b1, 64'd2, 4'b0100, 1};
    vt[13] = '{64'd3, 64'h41, 5'b10011, 1'b0, 64'd6, 4'b0000, 2};
    vt[14] = '{64'hF0, 64'h0F, 5'b00100, 1'b0, 64'hFF, 4'b0000, 1};
    vt[15] = '{64'd1, 64'd1, 5'b10100, 1'b0, 64'd0, 4'b0001, 2};

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset F", F, 64'd0);
    chk("reset status", 64'(status), 64'd0);

    for (int i = 0; i < 16; i++) do_op($sformatf("vec%0d", i), vt[i], 0);

    do_op("stall", '{64'd1, 64'd2, 5'b10000, 1'b0, 64'd4, 4'b0000, 3}, 5);

    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd40; FS = 5'b10100; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    chk("busy in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midreset in_ready", 64'(in_ready), 64'd1);
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset F", F, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clock); #1;
      seen |= out_valid;
    end
    chk("midreset no result", 64'(seen), 64'd0);

    do_op("after reset", vt[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
